// File: rtl/cla_add16_pipe.sv
// Two-stage pipelined 16-bit adder/subtractor on 4-bit carry-lookahead groups.
// Optional saturation on signed overflow when CLA_ADD16_SAT_EN is defined.
module cla_add16_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              sub,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic              cout,
  output logic              ovf,
  output logic              zero
);
  localparam int NGRP = WIDTH / GROUP;

  if (WIDTH != 16 || GROUP != 4) begin : g_bad_cfg
    $error("cla_add16_pipe supports only WIDTH=16, GROUP=4");
  end

  logic [WIDTH-1:0] w_beff, w_p, w_g, w_c, w_sum, w_res;
  logic [NGRP-1:0]  w_P, w_G;
  logic [NGRP:0]    w_cg;
  logic             w_c0, w_accept, w_s2_load, w_ovf;

  logic [WIDTH-1:0] r_p, r_g;
  logic [NGRP-1:0]  r_P, r_G;
  logic             r_c0, r_a15, r_b15, r_vld1;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero, r_vld2;

  // Flow control: stage 2 refills when empty or draining; stage 1 refills behind it.
  assign w_s2_load = r_vld1 && (!r_vld2 || out_ready);
  assign in_ready  = !r_vld1 || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  assign w_beff = sub ? ~b : b;
  assign w_c0   = sub | cin;
  assign w_p    = a ^ w_beff;
  assign w_g    = a & w_beff;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    assign w_P[k] = &w_p[4*k +: 4];
    assign w_G[k] = w_g[4*k+3]
                  | (w_p[4*k+3] & w_g[4*k+2])
                  | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                  | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);

    assign w_c[4*k]   = w_cg[k];
    assign w_c[4*k+1] = r_g[4*k] | (r_p[4*k] & w_cg[k]);
    assign w_c[4*k+2] = r_g[4*k+1] | (r_p[4*k+1] & r_g[4*k])
                      | (r_p[4*k+1] & r_p[4*k] & w_cg[k]);
    assign w_c[4*k+3] = r_g[4*k+2] | (r_p[4*k+2] & r_g[4*k+1])
                      | (r_p[4*k+2] & r_p[4*k+1] & r_g[4*k])
                      | ((&r_p[4*k +: 3]) & w_cg[k]);
  end

  // Second-level lookahead, fully expanded so no group waits on another.
  assign w_cg[0] = r_c0;
  assign w_cg[1] = r_G[0] | (r_P[0] & r_c0);
  assign w_cg[2] = r_G[1] | (r_P[1] & r_G[0]) | (r_P[1] & r_P[0] & r_c0);
  assign w_cg[3] = r_G[2] | (r_P[2] & r_G[1]) | (r_P[2] & r_P[1] & r_G[0])
                 | (r_P[2] & r_P[1] & r_P[0] & r_c0);
  assign w_cg[4] = r_G[3] | (r_P[3] & r_G[2]) | (r_P[3] & r_P[2] & r_G[1])
                 | (r_P[3] & r_P[2] & r_P[1] & r_G[0])
                 | (r_P[3] & r_P[2] & r_P[1] & r_P[0] & r_c0);

  assign w_sum = r_p ^ w_c;
  assign w_ovf = (r_a15 == r_b15) && (w_sum[WIDTH-1] != r_a15);

`ifdef CLA_ADD16_SAT_EN
  assign w_res = w_ovf ? (r_a15 ? 16'h8000 : 16'h7FFF) : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1 <= 1'b0;
      r_p    <= '0;
      r_g    <= '0;
      r_P    <= '0;
      r_G    <= '0;
      r_c0   <= 1'b0;
      r_a15  <= 1'b0;
      r_b15  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vld1 <= 1'b1;
        r_p    <= w_p;
        r_g    <= w_g;
        r_P    <= w_P;
        r_G    <= w_G;
        r_c0   <= w_c0;
        r_a15  <= a[WIDTH-1];
        r_b15  <= w_beff[WIDTH-1];
      end else if (w_s2_load) begin
        r_vld1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld2 <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_s2_load) begin
      r_vld2 <= 1'b1;
      r_sum  <= w_res;
      r_cout <= w_cg[NGRP];
      r_ovf  <= w_ovf;
      r_zero <= ~|w_res;
    end else if (out_ready) begin
      r_vld2 <= 1'b0;
    end
  end

  assign out_valid = r_vld2;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_cla_add16_pipe.sv
// Self-checking bench for cla_add16_pipe: directed cases, back-pressure, reset
// mid-flight and a long random run against an arithmetic reference queue.
module tb_cla_add16_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        sub = 1'b0, cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  cla_add16_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c, o, z;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic on the effective operands.
  task automatic push_exp(input logic [15:0] xa, input logic [15:0] xb,
                          input logic xs, input logic xc);
    logic [15:0] be;
    logic [16:0] r;
    exp_t        e;
    be  = xs ? ~xb : xb;
    r   = {1'b0, xa} + {1'b0, be} + 17'(xs | xc);
    e.s = r[15:0];
    e.c = r[16];
    e.o = (xa[15] == be[15]) && (r[15] != xa[15]);
`ifdef CLA_ADD16_SAT_EN
    if (e.o) e.s = xa[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.z = (e.s == 16'h0000);
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    chk("q_nonempty", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sum", 32'(sum), 32'(e.s));
      chk("cout", 32'(cout), 32'(e.c));
      chk("ovf", 32'(ovf), 32'(e.o));
      chk("zero", 32'(zero), 32'(e.z));
    end
  endtask

  // One clock: observe transfers mid-cycle, then advance past the edge.
  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) check_out();
    if (acc) push_exp(a, b, sub, cin);
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [15:0] xa, input logic [15:0] xb,
                       input logic xs, input logic xc);
    in_valid = 1'b1; a = xa; b = xb; sub = xs; cin = xc;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(acc);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] bp_a[4] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0F0F};
  logic [15:0] bp_b[4] = '{16'h1111, 16'h8000, 16'h0001, 16'h0F0F};
  logic        bp_s[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    bit acc;
    int idx, budget;

    // Reset state.
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", 32'({cout, ovf, zero}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full propagate chain, with latency check.
    out_ready = 1'b1;
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    cycle(acc);
    chk("accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    chk("lat_early", 32'(out_valid), 32'd0);
    cycle(acc);
    chk("lat_two", 32'(out_valid), 32'd1);
    chk("prop_sum", 32'(sum), 32'h0);
    chk("prop_cout", 32'(cout), 32'd1);
    drain();

    // Subtract with borrow, then signed overflow.
    drive(16'h0003, 16'h0005, 1'b1, 1'b0);
    cycle(acc);
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    cycle(acc);
    drive(16'h8000, 16'h0001, 1'b1, 1'b1);
    cycle(acc);
    drain();

    // Back-pressure: 4 ops, out_ready low for the first cycles.
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      drive(bp_a[idx], bp_b[idx], bp_s[idx], 1'b0);
      cycle(acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_sum", 32'(sum), 32'(16'h1234 + 16'h1111));
    out_ready = 1'b1;
    budget = 0;
    while (idx < 4 && budget < 20) begin
      drive(bp_a[idx], bp_b[idx], bp_s[idx], 1'b0);
      cycle(acc);
      if (acc) idx++;
      budget++;
    end
    chk("bp_all_in", 32'(idx), 32'd4);
    drain();

    // Reset with two ops in flight.
    out_ready = 1'b0;
    drive(16'h0101, 16'h0202, 1'b0, 1'b0);
    cycle(acc);
    drive(16'h0303, 16'h0404, 1'b0, 1'b1);
    cycle(acc);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic with random back-pressure.
    idx = 0;
    budget = 0;
    while (idx < 10000 && budget < 40000) begin
      if ($urandom_range(0, 3) != 0)
        drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else
        in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) idx++;
      budget++;
    end
    chk("rand_count", 32'(idx), 32'd10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_add16_pipe.md
Name: cla_add16_pipe

Overview:
- Two-stage pipelined 16-bit adder/subtractor built on 4-bit carry-lookahead groups.
- Stage 1 registers operands and produces per-bit propagate/generate terms plus group P/G for four 4-bit groups.
- Stage 2 runs the second-level lookahead (group carries) and the in-group carries, then forms sum and flags.
- Sits between the register-file read stage and the ALU result mux; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand width; fixed at 16 (4 groups x 4 bits); any other value is a elaboration error.
- GROUP, 4, bits per lookahead group; fixed at 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  16  operand A.
- b  in  16  operand B.
- sub  in  1  1 = A - B (B inverted, carry-in forced 1); 0 = A + B + cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  downstream accepts result this cycle.
- sum  out  16  result.
- cout  out  1  carry out of bit 15 (for sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valid bits clear; sum, cout, ovf, zero = 0; out_valid = 0. Releasing reset takes effect on the next clk edge.
- Reset mid-operation discards all in-flight operations; nothing is emitted afterwards.
- Transfers:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Stage 1 capture on acceptance:
  - b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
  - p[i] = a[i]^b_eff[i]; g[i] = a[i]&b_eff[i].
  - Per group k: Pk = &p[4k+3:4k].
  - Gk = g3 | p3g2 | p3p2g1 | p3p2p1g0 (within the group).
  - Registered: p, g, Pk, Gk, c0, a[15], b_eff[15], valid1.
- Stage 2 (registered outputs):
  - Group carry-ins: C_g0 = c0; C_g(k+1) = Gk | Pk&C_gk, fully expanded (no ripple chain).
  - In-group carries use the same 4-bit lookahead equations.
  - sum[i] = p[i]^carry_into[i]; cout = carry out of group 3.
  - ovf = (a15 == b_eff15) && (sum15 != a15); zero = ~|sum.
- Latency: 2 cycles from acceptance to out_valid with no stalls. Throughput is 1 op/cycle.
- Stall/flow control:
  - stage2_load = valid1 && (!out_valid || out_ready).
  - in_ready = !valid1 || stage2_load (combinational, no combinational path from in_valid).
  - When out_valid && !out_ready: sum/flags hold stable and stage 1 holds if full.
- Simultaneous events:
  - Consume and load in the same cycle: stage 2 takes the new result, out_valid stays 1.
  - Accept into an empty stage 1 while stage 2 is draining: both happen in that cycle.
- Invariant: outputs change only on a stage-2 load.
- Wrap-around is modular 2^16; cout/ovf report it.

Optional Feature:
- Macro: CLA_ADD16_SAT_EN.
- Defined:
  - When ovf = 1, sum saturates to 16'h7FFF if a15 = 0, else 16'h8000.
  - zero is computed on the saturated value.
  - ovf, cout and latency are unchanged.
- Undefined: sum wraps modulo 2^16; no saturation logic is present.

Test Plan:
- Reset: assert rst_n=0 mid-flight with two ops in pipe -> out_valid=0, sum=0 immediately; after release no stale results appear.
- Add with full propagate: a=16'hFFFF, b=16'h0000, cin=1, sub=0 -> 2 cycles later sum=16'h0000, cout=1, zero=1, ovf=0.
- Subtract/borrow: a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0, ovf=0, zero=0.
- Signed overflow: a=16'h7FFF, b=16'h0001, sub=0, cin=0 -> sum=16'h8000, ovf=1 (with CLA_ADD16_SAT_EN: sum=16'h7FFF, ovf=1).
- Back-pressure: stream 4 ops with out_ready=0 for 3 cycles -> in_ready drops after 2 ops accepted; output holds first result stable; all 4 results emerge in order once out_ready=1, none lost or duplicated.
- Random: 10k random a/b/sub/cin with random out_ready -> every result matches the reference model {cout,sum} = a + b_eff + c0, ovf/zero correct, order preserved.
